alu_port_arbiter: RTL and testbench

ALU_PORT_ARBITER -- requirements
Module: alu_port_arbiter

---
 rtl/alu_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_port_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_port_arbiter.sv
// Round-robin front end letting two requesters share one fixed-latency ALU, one transaction in flight.
// Optional macro ALU_ARB_IRQ_AUTOCLR_EN: ALU interrupt is cleared by an IRQCLR state before the response.
module alu_port_arbiter #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 2,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_mode,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_mode,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_irq,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_irq,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [OP_W-1:0]   alu_op_a,
    output logic [OP_W-1:0]   alu_op_b,
    output logic              alu_enable,
    output logic              alu_enable_a,
    output logic              alu_enable_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_irq,
    output logic              alu_irq_clr,
    input  logic              irq_ack,
    output logic              irq_pending,
    output logic              busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
`ifdef ALU_ARB_IRQ_AUTOCLR_EN
    localparam logic [2:0] S_IRQCLR = 3'd3;
`endif
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              prio_q;
    logic              id_q;
    logic              mode_q;
    logic [DATA_W-1:0] ain_q, bin_q;
    logic [OP_W-1:0]   opa_q, opb_q;
    logic [DATA_W-1:0] data_q;
    logic              irq_q;
    logic              pend_q;

    logic [1:0]        req_valid_w;
    logic [1:0]        req_ready_w;
    logic [1:0]        req_mode_w;
    logic [OP_W-1:0]   req_op_w   [2];
    logic [DATA_W-1:0] req_a_w    [2];
    logic [DATA_W-1:0] req_b_w    [2];
    logic [1:0]        rsp_ready_w;
    logic [1:0]        rsp_valid_w;
    logic [DATA_W-1:0] rsp_data_w [2];
    logic [1:0]        rsp_irq_w;

    logic              grant_id;
    logic              accept;
    logic              capture;
    logic              rsp_done;

    assign req_valid_w = {req1_valid, req0_valid};
    assign req_mode_w  = {req1_mode, req0_mode};
    assign rsp_ready_w = {rsp1_ready, rsp0_ready};
    assign req_op_w[0] = req0_op;
    assign req_op_w[1] = req1_op;
    assign req_a_w[0]  = req0_a;
    assign req_a_w[1]  = req1_a;
    assign req_b_w[0]  = req0_b;
    assign req_b_w[1]  = req1_b;

    // With both requesting, prio_q names the one that was not granted last.
    assign grant_id = (&req_valid_w) ? prio_q : ~req_valid_w[0];
    assign accept   = (state_q == S_IDLE) && (|req_valid_w) && !rst;
    assign capture  = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign rsp_done = (state_q == S_RESP) && rsp_ready_w[id_q];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready_w[gi] = accept && (grant_id == 1'(gi));
            assign rsp_valid_w[gi] = (state_q == S_RESP) && (id_q == 1'(gi));
            assign rsp_data_w[gi]  = (id_q == 1'(gi)) ? data_q : '0;
            assign rsp_irq_w[gi]   = (id_q == 1'(gi)) && irq_q;
        end
    endgenerate

    assign req0_ready = req_ready_w[0];
    assign req1_ready = req_ready_w[1];
    assign rsp0_valid = rsp_valid_w[0];
    assign rsp1_valid = rsp_valid_w[1];
    assign rsp0_data  = rsp_data_w[0];
    assign rsp1_data  = rsp_data_w[1];
    assign rsp0_irq   = rsp_irq_w[0];
    assign rsp1_irq   = rsp_irq_w[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = 4'(ALU_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
`ifdef ALU_ARB_IRQ_AUTOCLR_EN
                    state_d = alu_irq ? S_IRQCLR : S_RESP;
`else
                    state_d = S_RESP;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef ALU_ARB_IRQ_AUTOCLR_EN
            S_IRQCLR: begin
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if (rsp_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            mode_q  <= 1'b0;
            ain_q   <= '0;
            bin_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            data_q  <= '0;
            irq_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                prio_q <= ~grant_id;
                id_q   <= grant_id;
                mode_q <= req_mode_w[grant_id];
                ain_q  <= req_a_w[grant_id];
                bin_q  <= req_b_w[grant_id];
                // Only the opcode port for the selected bank moves; the other keeps its last value.
                if (req_mode_w[grant_id]) begin
                    opb_q <= req_op_w[grant_id];
                end else begin
                    opa_q <= req_op_w[grant_id];
                end
            end
            if (capture) begin
                data_q <= alu_out;
                irq_q  <= alu_irq;
            end
            if (capture && alu_irq) begin
                pend_q <= 1'b1;
            end else if (irq_ack) begin
                pend_q <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_IRQ_AUTOCLR_EN
    assign alu_irq_clr = (state_q == S_IRQCLR);
`else
    logic irq_clr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_clr_q <= 1'b0;
        end else begin
            irq_clr_q <= irq_ack;
        end
    end

    assign alu_irq_clr = irq_clr_q;
`endif

    assign alu_in_a     = ain_q;
    assign alu_in_b     = bin_q;
    assign alu_op_a     = opa_q;
    assign alu_op_b     = opb_q;
    assign alu_enable   = (state_q == S_ISSUE);
    assign alu_enable_a = (state_q == S_ISSUE) && !mode_q;
    assign alu_enable_b = (state_q == S_ISSUE) && mode_q;
    assign irq_pending  = pend_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Directed bench for alu_port_arbiter: transaction-timeline model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_alu_port_arbiter;

    localparam int LAT = 2;
`ifdef ALU_ARB_IRQ_AUTOCLR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_mode = 1'b0;
    logic [1:0] req0_op = 2'd0;
    logic [7:0] req0_a = 8'd0, req0_b = 8'd0;
    logic       req0_ready;
    logic       req1_valid = 1'b0, req1_mode = 1'b0;
    logic [1:0] req1_op = 2'd0;
    logic [7:0] req1_a = 8'd0, req1_b = 8'd0;
    logic       req1_ready;
    logic       rsp0_valid, rsp0_irq, rsp1_valid, rsp1_irq;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] alu_in_a, alu_in_b, alu_out;
    logic [1:0] alu_op_a, alu_op_b;
    logic       alu_enable, alu_enable_a, alu_enable_b;
    logic       alu_irq, alu_irq_clr, irq_pending, busy;
    logic       irq_ack = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    alu_port_arbiter #(.DATA_W(8), .OP_W(2), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_irq(rsp0_irq),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_irq(rsp1_irq),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
        .alu_out(alu_out), .alu_irq(alu_irq), .alu_irq_clr(alu_irq_clr),
        .irq_ack(irq_ack), .irq_pending(irq_pending), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: op 0 and, 1 add, 2 sub, 3 xor; interrupt on an all-ones result.
    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a + b;
            2'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    logic alu_sel_b = 1'b0;
    always @(posedge clk) if (alu_enable) alu_sel_b <= alu_enable_b;
    assign alu_out = alu_f(alu_sel_b ? alu_op_b : alu_op_a, alu_in_a, alu_in_b);
    assign alu_irq = (alu_out == 8'hff);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a transaction is a timeline of offsets from its grant cycle.
    bit         m_busy, m_id, m_mode, m_prio, m_pend, m_clr, m_irq;
    int         m_t;
    logic [1:0] m_op, m_opa, m_opb;
    logic [7:0] m_a, m_b, m_res, m_ain, m_bin;

    initial begin : cmp_proc
        logic [1:0] e_ready, e_rv;
        bit         e_en, e_ena, e_enb, e_clr, acc, g, cap;
        int         rk;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_t = 0; m_prio = 0; m_pend = 0; m_clr = 0; m_irq = 0;
                m_ain = 0; m_bin = 0; m_opa = 0; m_opb = 0; m_res = 0;
            end else begin
                e_ready = 2'b00; e_rv = 2'b00; e_en = 0; e_ena = 0; e_enb = 0; acc = 0; g = 0;
                e_clr = AUTOCLR ? 1'b0 : m_clr;
                rk = 2 + LAT + ((AUTOCLR && m_irq) ? 1 : 0);
                if (!m_busy) begin
                    if (req0_valid || req1_valid) begin
                        acc = 1;
                        g = (req0_valid && req1_valid) ? m_prio : !req0_valid;
                        e_ready[g] = 1'b1;
                    end
                end else begin
                    if (m_t == 1) begin
                        e_en = 1; e_ena = !m_mode; e_enb = m_mode;
                    end
                    if (m_t >= rk) e_rv[m_id] = 1'b1;
                    if (AUTOCLR && m_irq && m_t == 2 + LAT) e_clr = 1;
                end
                chk("req0_ready", req0_ready, e_ready[0]);
                chk("req1_ready", req1_ready, e_ready[1]);
                chk("rsp0_valid", rsp0_valid, e_rv[0]);
                chk("rsp1_valid", rsp1_valid, e_rv[1]);
                chk("busy", busy, m_busy);
                chk("alu_enable", alu_enable, e_en);
                chk("alu_enable_a", alu_enable_a, e_ena);
                chk("alu_enable_b", alu_enable_b, e_enb);
                chk("alu_in_a", alu_in_a, m_ain);
                chk("alu_in_b", alu_in_b, m_bin);
                chk("alu_op_a", alu_op_a, m_opa);
                chk("alu_op_b", alu_op_b, m_opb);
                chk("irq_pending", irq_pending, m_pend);
                chk("alu_irq_clr", alu_irq_clr, e_clr);
                if (e_rv[0]) begin
                    chk("rsp0_data", rsp0_data, m_res);
                    chk("rsp0_irq", rsp0_irq, m_irq);
                end
                if (e_rv[1]) begin
                    chk("rsp1_data", rsp1_data, m_res);
                    chk("rsp1_irq", rsp1_irq, m_irq);
                end
                m_clr = irq_ack;
                cap = m_busy && (m_t == 1 + LAT);
                if (cap) begin
                    m_res = alu_f(m_op, m_a, m_b);
                    m_irq = (m_res == 8'hff);
                end
                if (cap && m_irq) m_pend = 1;
                else if (irq_ack) m_pend = 0;
                if (!m_busy) begin
                    if (acc) begin
                        m_busy = 1; m_t = 1; m_id = g; m_prio = !g;
                        m_mode = g ? req1_mode : req0_mode;
                        m_op   = g ? req1_op : req0_op;
                        m_a    = g ? req1_a : req0_a;
                        m_b    = g ? req1_b : req0_b;
                        m_ain  = m_a;
                        m_bin  = m_b;
                        if (m_mode) m_opb = m_op;
                        else m_opa = m_op;
                    end
                end else if (e_rv[m_id] && (m_id ? rsp1_ready : rsp0_ready)) begin
                    m_busy = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input bit v, input bit mode, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            req1_valid = v; req1_mode = mode; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_mode = mode; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic wait_grant(output bit got, output bit gid, output int gc);
        got = 0; gid = 0; gc = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got = 1; gid = req1_ready; gc = cyc;
            end
            step();
        end
    endtask

    task automatic wait_rsp(input bit id, output bit got, output int rc,
                            output logic [7:0] data, output bit irq);
        got = 0; rc = 0; data = 0; irq = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (id ? rsp1_valid : rsp0_valid) begin
                got = 1; rc = cyc;
                data = id ? rsp1_data : rsp0_data;
                irq = id ? rsp1_irq : rsp0_irq;
            end
            step();
        end
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (!busy) ok = 1;
            step();
        end
        chk({nm, " idle"}, ok, 1);
    endtask

    task automatic txn(input string nm, input bit id, input bit mode, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_data, input bit exp_irq);
        bit got, gid, irq;
        int gc, rc;
        int exp_lat = (AUTOCLR && exp_irq) ? 5 : 4;
        logic [7:0] data;
        set_req(id, 1, mode, op, a, b);
        wait_grant(got, gid, gc);
        chk({nm, " grant"}, got, 1);
        chk({nm, " grant id"}, gid, id);
        set_req(id, 0, mode, op, a, b);
        wait_rsp(id, got, rc, data, irq);
        chk({nm, " rsp seen"}, got, 1);
        chk({nm, " latency"}, rc - gc, exp_lat);
        chk({nm, " data"}, data, exp_data);
        chk({nm, " irq"}, irq, exp_irq);
        $display("txn %s: req%0d mode=%0d op=%0d a=%02h b=%02h -> data=%02h irq=%0d", nm, id, mode, op, a, b, data, irq);
    endtask

    typedef struct {
        bit         id;
        bit         mode;
        logic [1:0] op;
        logic [7:0] a, b, res;
        bit         irq;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        bit got, gid, irq;
        int gc, rc;
        logic [7:0] data;
        int gseq[$];

        vt[0] = '{id: 1'b1, mode: 1'b1, op: 2'd0, a: 8'hf3, b: 8'h3c, res: 8'h30, irq: 1'b0};
        vt[1] = '{id: 1'b0, mode: 1'b1, op: 2'd2, a: 8'h03, b: 8'h05, res: 8'hfe, irq: 1'b0};
        vt[2] = '{id: 1'b1, mode: 1'b0, op: 2'd3, a: 8'h0f, b: 8'hf0, res: 8'hff, irq: 1'b1};
        vt[3] = '{id: 1'b0, mode: 1'b0, op: 2'd1, a: 8'hff, b: 8'h02, res: 8'h01, irq: 1'b0};

        step(); step(); step();
        rst = 0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset rsp0_valid", rsp0_valid, 0);
        chk("reset alu_enable", alu_enable, 0);
        chk("reset alu_in_a", alu_in_a, 8'h00);
        chk("reset irq_pending", irq_pending, 0);
        chk("reset alu_irq_clr", alu_irq_clr, 0);
        step();

        // Both requesters held valid: grants alternate starting from requester 0.
        set_req(0, 1, 0, 2'd1, 8'h03, 8'h04);
        set_req(1, 1, 1, 2'd3, 8'h5a, 8'h0f);
        for (int n = 0; n < 80 && gseq.size() < 4; n++) begin
            @(negedge clk);
            if (req0_ready) gseq.push_back(0);
            if (req1_ready) gseq.push_back(1);
            if (rsp0_valid) chk("rr rsp0 data", rsp0_data, 8'h07);
            if (rsp1_valid) chk("rr rsp1 data", rsp1_data, 8'h55);
            step();
        end
        req0_valid = 0;
        req1_valid = 0;
        chk("rr grant count", gseq.size(), 4);
        if (gseq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rr grant order", gseq[i], i % 2);
                $display("rr grant %0d -> req%0d", i, gseq[i]);
            end
        end
        wait_idle("rr");

        txn("basic", 0, 0, 2'd1, 8'h10, 8'h05, 8'h15, 0);
        foreach (vt[i]) txn("table", vt[i].id, vt[i].mode, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].irq);

        // Response back-pressure on requester 1 while requester 0 waits.
        rsp1_ready = 0;
        set_req(1, 1, 1, 2'd2, 8'h40, 8'h01);
        wait_grant(got, gid, gc);
        chk("hold grant", got, 1);
        chk("hold grant id", gid, 1);
        set_req(1, 0, 1, 2'd2, 8'h40, 8'h01);
        set_req(0, 1, 0, 2'd0, 8'hcc, 8'h0f);
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (rsp1_valid) got = 1;
            step();
        end
        chk("hold rsp seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold valid", rsp1_valid, 1);
            chk("hold data", rsp1_data, 8'h3f);
            chk("hold no grant", req0_ready, 0);
            $display("hold cycle %0d: rsp1_valid=%0d data=%02h", i, rsp1_valid, rsp1_data);
            step();
        end
        rsp1_ready = 1;
        @(negedge clk);
        chk("hold final valid", rsp1_valid, 1);
        chk("hold no grant at completion", req0_ready, 0);
        step();
        wait_grant(got, gid, gc);
        chk("after hold grant", got, 1);
        chk("after hold grant id", gid, 0);
        set_req(0, 0, 0, 2'd0, 8'hcc, 8'h0f);
        wait_rsp(0, got, rc, data, irq);
        chk("after hold rsp seen", got, 1);
        chk("after hold data", data, 8'h0c);

        // Interrupt result, then software acknowledge.
        txn("irq", 0, 0, 2'd1, 8'hf0, 8'h0f, 8'hff, 1);
        @(negedge clk);
        chk("irq pending set", irq_pending, 1);
        step();
        irq_ack = 1;
        @(negedge clk);
`ifndef ALU_ARB_IRQ_AUTOCLR_EN
        chk("irq clr before ack sampled", alu_irq_clr, 0);
`endif
        step();
        irq_ack = 0;
        @(negedge clk);
        chk("irq pending cleared", irq_pending, 0);
`ifndef ALU_ARB_IRQ_AUTOCLR_EN
        chk("irq clr pulse", alu_irq_clr, 1);
`endif
        step();
        @(negedge clk);
        chk("irq clr pulse end", alu_irq_clr, 0);
        $display("irq ack: pending=%0d clr=%0d", irq_pending, alu_irq_clr);
        step();

        // Reset in the middle of WAIT discards the transaction.
        set_req(0, 1, 0, 2'd1, 8'h01, 8'h02);
        wait_grant(got, gid, gc);
        chk("rst txn grant", got, 1);
        set_req(0, 0, 0, 2'd1, 8'h01, 8'h02);
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst rsp0_valid", rsp0_valid, 0);
        chk("rst alu_in_a", alu_in_a, 8'h00);
        chk("rst alu_in_b", alu_in_b, 8'h00);
        chk("rst alu_op_a", alu_op_a, 2'd0);
        chk("rst alu_enable", alu_enable, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst no response", rsp0_valid, 0);
            step();
        end
        set_req(0, 1, 0, 2'd0, 8'h33, 8'h11);
        set_req(1, 1, 1, 2'd1, 8'h20, 8'h08);
        wait_grant(got, gid, gc);
        chk("rst prio grant", got, 1);
        chk("rst prio id", gid, 0);
        $display("after reset both valid -> req%0d granted", gid);
        req0_valid = 0;
        req1_valid = 0;
        wait_idle("rst prio");
        txn("post rst", 1, 0, 2'd1, 8'h20, 8'h08, 8'h28, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
